// File: rtl/bist_checker.sv
// bist_checker: SRAM BIST response analyzer that compares read data
// against the generator's expected value after the macro read latency.
module bist_checker #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  en,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] check,
    input  logic                  pg_done,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [CNT_WIDTH-1:0]  fail_cnt,
    output logic [DATA_WIDTH-1:0] fail_bits,
    output logic [ADDR_WIDTH-1:0] first_addr,
    output logic [DATA_WIDTH-1:0] first_data,
    output logic [DATA_WIDTH-1:0] first_exp
);

    localparam int LW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int LAST = READ_LATENCY - 1;
    localparam logic [LW-1:0] DRAIN_LAST = LW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   drain_q, drain_d;

    logic                  pv_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] pa_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pc_q [READ_LATENCY];

    logic                  issue;
    logic                  slot_v;
    logic                  miss;
    logic [DATA_WIDTH-1:0] diff;

    assign issue  = en && re && !pg_done && (state_q == RUN);
    assign slot_v = pv_q[LAST] && ((state_q == RUN) || (state_q == DRAIN));
    assign diff   = dout ^ pc_q[LAST];
    assign miss   = slot_v && (|diff);

    // The macro never stalls, so the tracking pipe shifts every cycle.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pv_q[i] <= 1'b0;
                pa_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= issue;
            pa_q[0] <= addr;
            pc_q[0] <= check;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
                pc_q[i] <= pc_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (pg_done) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= IDLE;
            drain_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            busy    <= (state_d == RUN) || (state_d == DRAIN);
            done    <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            fail       <= 1'b0;
            fail_cnt   <= '0;
            fail_bits  <= '0;
            first_addr <= '0;
            first_data <= '0;
            first_exp  <= '0;
        end else if (miss) begin
            fail      <= 1'b1;
            fail_bits <= fail_bits | diff;
            if (fail_cnt != '1) begin
                fail_cnt <= fail_cnt + 1'b1;
            end
            if (!fail) begin
                first_addr <= pa_q[LAST];
                first_data <= dout;
                first_exp  <= pc_q[LAST];
            end
        end
    end

endmodule

// File: tb/tb_bist_checker.sv
// Bench for bist_checker: two latency/counter configurations driven in
// parallel, checked against a cycle-indexed read history model.
module tb_bist_checker;

    logic       clk = 1'b0;
    logic       rstb, en, re, pg_done;
    logic [7:0] addr, check, dout;

    logic       b1, d1, f1, b3, d3, f3;
    logic [15:0] c1;
    logic [1:0]  c3;
    logic [7:0]  fb1, fa1, fd1, fe1, fb3, fa3, fd3, fe3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bist_checker #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(1), .CNT_WIDTH(16)
    ) u_l1 (
        .clk(clk), .rstb(rstb), .en(en), .re(re), .addr(addr),
        .check(check), .pg_done(pg_done), .dout(dout),
        .busy(b1), .done(d1), .fail(f1), .fail_cnt(c1),
        .fail_bits(fb1), .first_addr(fa1), .first_data(fd1),
        .first_exp(fe1)
    );

    bist_checker #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(3), .CNT_WIDTH(2)
    ) u_l3 (
        .clk(clk), .rstb(rstb), .en(en), .re(re), .addr(addr),
        .check(check), .pg_done(pg_done), .dout(dout),
        .busy(b3), .done(d3), .fail(f3), .fail_cnt(c3),
        .fail_bits(fb3), .first_addr(fa3), .first_data(fd3),
        .first_exp(fe3)
    );

    // Reference model: reads logged by cycle index since reset release.
    int         lat  [2] = '{1, 3};
    int         cmax [2] = '{65535, 3};
    bit         live = 0;
    int         k;
    int         pd;
    bit         iss_v [256];
    logic [7:0] iss_a [256];
    logic [7:0] iss_e [256];
    bit         m_fail [2];
    int         m_cnt  [2];
    logic [7:0] m_bits [2];
    logic [7:0] m_fa   [2];
    logic [7:0] m_fd   [2];
    logic [7:0] m_fe   [2];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0] df;
        int         s;
        if (!rstb) begin
            live = 1;
            k    = 0;
            pd   = -1;
            for (int i = 0; i < 256; i++) iss_v[i] = 0;
            for (int m = 0; m < 2; m++) begin
                m_fail[m] = 0;
                m_cnt[m]  = 0;
                m_bits[m] = 0;
                m_fa[m]   = 0;
                m_fd[m]   = 0;
                m_fe[m]   = 0;
            end
        end else if (live) begin
            for (int m = 0; m < 2; m++) begin
                s = k - lat[m];
                if (s >= 0 && iss_v[s]) begin
                    df = dout ^ iss_e[s];
                    if (df != 0) begin
                        if (!m_fail[m]) begin
                            m_fa[m] = iss_a[s];
                            m_fd[m] = dout;
                            m_fe[m] = iss_e[s];
                        end
                        m_fail[m] = 1;
                        if (m_cnt[m] < cmax[m]) m_cnt[m]++;
                        m_bits[m] = m_bits[m] | df;
                    end
                end
            end
            if (k >= 1 && pd < 0) begin
                if (en && re && !pg_done) begin
                    iss_v[k] = 1;
                    iss_a[k] = addr;
                    iss_e[k] = check;
                end
                if (pg_done) pd = k;
            end
            if (k < 255) k++;
        end
    endtask

    task automatic model_check();
        bit eb, ed;
        if (!live) return;
        for (int m = 0; m < 2; m++) begin
            eb = (k >= 1) && (pd < 0 || k <= pd + lat[m]);
            ed = (pd >= 0) && (k >= pd + lat[m] + 1);
            chk($sformatf("i%0d busy", m), m ? b3 : b1, eb);
            chk($sformatf("i%0d done", m), m ? d3 : d1, ed);
            chk($sformatf("i%0d fail", m), m ? f3 : f1, m_fail[m]);
            chk($sformatf("i%0d cnt", m), m ? {14'd0, c3} : c1, m_cnt[m]);
            chk($sformatf("i%0d bits", m), m ? fb3 : fb1, m_bits[m]);
            chk($sformatf("i%0d faddr", m), m ? fa3 : fa1, m_fa[m]);
            chk($sformatf("i%0d fdata", m), m ? fd3 : fd1, m_fd[m]);
            chk($sformatf("i%0d fexp", m), m ? fe3 : fe1, m_fe[m]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset(input logic pd_in);
        rstb = 0; en = 0; re = 0; pg_done = pd_in;
        addr = 0; check = 0; dout = 0;
        tick();
        rstb = 1;
    endtask

    function automatic logic [7:0] rv();
        case ($urandom % 4)
            0: rv = 8'h00;
            1: rv = 8'hFF;
            2: rv = 8'hA5;
            default: rv = 8'($urandom);
        endcase
    endfunction

    typedef struct packed {
        logic       e, r, p;
        logic [7:0] a, c, d;
        logic       xb, xd, xf;
        logic [1:0] xn;
        logic [7:0] xbits, xfa;
    } vec_t;

    function automatic vec_t mk(logic e_, logic r_, logic p_,
                                logic [7:0] a_, logic [7:0] c_,
                                logic [7:0] d_, logic xb_, logic xd_,
                                logic xf_, logic [1:0] xn_,
                                logic [7:0] xbits_, logic [7:0] xfa_);
        mk = '{e_, r_, p_, a_, c_, d_, xb_, xd_, xf_, xn_, xbits_, xfa_};
    endfunction

    vec_t tab [11];

    initial begin
        rstb = 0; en = 0; re = 0; pg_done = 0;
        addr = 0; check = 0; dout = 0;

        // Latency sweep and drain timing on the RL=3 instance.
        tab[0]  = mk(1, 1, 0, 8'h11, 8'h5A, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
        tab[1]  = mk(1, 1, 0, 8'h2A, 8'hFF, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
        tab[2]  = mk(0, 1, 0, 8'h33, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
        tab[3]  = mk(1, 0, 0, 8'h34, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
        tab[4]  = mk(0, 0, 0, 8'h00, 8'h00, 8'hFE, 1, 0, 0, 0, 8'h00, 8'h00);
        tab[5]  = mk(1, 1, 1, 8'h35, 8'h00, 8'h77, 1, 0, 1, 1, 8'h01, 8'h2A);
        tab[6]  = mk(0, 0, 1, 8'h00, 8'h00, 8'h12, 1, 0, 1, 1, 8'h01, 8'h2A);
        tab[7]  = mk(0, 0, 1, 8'h00, 8'h00, 8'h00, 1, 0, 1, 1, 8'h01, 8'h2A);
        tab[8]  = mk(0, 0, 1, 8'h00, 8'h00, 8'h99, 1, 0, 1, 1, 8'h01, 8'h2A);
        tab[9]  = mk(1, 1, 0, 8'h36, 8'h00, 8'h55, 0, 1, 1, 1, 8'h01, 8'h2A);
        tab[10] = mk(1, 1, 0, 8'h37, 8'h00, 8'h55, 0, 1, 1, 1, 8'h01, 8'h2A);

        do_reset(0);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("tab%0d busy", i), b3, tab[i].xb);
            chk($sformatf("tab%0d done", i), d3, tab[i].xd);
            chk($sformatf("tab%0d fail", i), f3, tab[i].xf);
            chk($sformatf("tab%0d cnt", i), c3, tab[i].xn);
            chk($sformatf("tab%0d bits", i), fb3, tab[i].xbits);
            chk($sformatf("tab%0d faddr", i), fa3, tab[i].xfa);
            en = tab[i].e; re = tab[i].r; pg_done = tab[i].p;
            addr = tab[i].a; check = tab[i].c; dout = tab[i].d;
            tick();
        end
        chk("sweep fdata", fd3, 8'hFE);
        chk("sweep fexp", fe3, 8'hFF);

        // Six back-to-back miscompares against a 2-bit counter.
        do_reset(0);
        for (int c = 0; c < 11; c++) begin
            if (c == 7) chk("sat cnt3", c3, 2'd3);
            en    = (c >= 1 && c <= 6);
            re    = en;
            addr  = 8'h40 + 8'(c - 1);
            check = 8'h00;
            dout  = (c >= 4 && c <= 9) ? 8'(1 << (c - 4)) : 8'h00;
            tick();
        end
        chk("sat cnt end", c3, 2'd3);
        chk("sat bits", fb3, 8'h3F);
        chk("sat faddr", fa3, 8'h40);
        chk("sat fdata", fd3, 8'h01);
        chk("sat fexp", fe3, 8'h00);

        // Reset with two failing reads still in flight.
        do_reset(0);
        dout = 8'hFF;
        tick();
        en = 1; re = 1; check = 8'h00; addr = 8'h10;
        tick();
        addr = 8'h11;
        tick();
        en = 0; re = 0; rstb = 0;
        tick();
        rstb = 1;
        chk("rst busy", b3, 1'b0);
        chk("rst done", d3, 1'b0);
        chk("rst fail", f3, 1'b0);
        chk("rst cnt", c3, 2'd0);
        chk("rst bits", fb3, 8'h00);
        for (int c = 0; c < 5; c++) tick();
        chk("rst stale fail", f3, 1'b0);

        // pg_done already high at reset release.
        do_reset(1);
        en = 1; re = 1; dout = 8'h3C; check = 8'hC3;
        for (int c = 0; c < 4; c++) tick();
        chk("pd0 done early", d3, 1'b0);
        chk("pd0 busy", b3, 1'b1);
        tick();
        chk("pd0 done", d3, 1'b1);
        chk("pd0 busy end", b3, 1'b0);
        chk("pd0 cnt", c3, 2'd0);
        chk("pd0 fail", f3, 1'b0);

        // Randomized episodes, some with a mid-run reset.
        for (int ep = 0; ep < 40; ep++) begin
            int len;
            do_reset(0);
            len = $urandom_range(2, 40);
            for (int c = 0; c < len + 10; c++) begin
                en      = ($urandom % 4) != 0;
                re      = ($urandom % 3) != 0;
                addr    = 8'($urandom);
                check   = rv();
                dout    = rv();
                pg_done = (c >= len) && (c == len || ($urandom % 2) == 1);
                rstb    = ($urandom % 64) != 0;
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
